// File: rtl/uart_tx_frame.sv
// UART transmitter: serializes a latched word as start, LSB-first data,
// optional parity and stop bits, each bit held for PRESCALE clock cycles.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [IDX_W-1:0]      bitIdx_q, bitIdx_d;
  logic [PS_W-1:0]       presc_q, presc_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  parEn_q, parEn_d;
  logic                  parTyp_q, parTyp_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic                  tick;
  logic                  parityBit;

  // tick marks the last cycle of the current bit period
  assign tick      = (presc_q == PS_W'(PRESCALE - 1));
  assign parityBit = parTyp_q ? ~^data_q : ^data_q;

  always_comb begin
    state_d  = state_q;
    bitIdx_d = bitIdx_q;
    presc_d  = '0;
    data_d   = data_q;
    parEn_d  = parEn_q;
    parTyp_d = parTyp_q;
    tx_d     = tx_q;
    busy_d   = busy_q;

    if (state_q != IDLE) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (Data_Valid) begin
          data_d   = P_DATA;
          parEn_d  = PAR_EN;
          parTyp_d = PAR_TYP;
          state_d  = START;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d  = DATA;
          bitIdx_d = '0;
          tx_d     = data_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bitIdx_q == IDX_W'(DATA_WIDTH - 1)) begin
            if (parEn_q) begin
              state_d = PARITY;
              tx_d    = parityBit;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
            tx_d     = data_q[bitIdx_q + 1'b1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        // Leaving STOP always passes through one IDLE cycle before a new frame
        if (tick) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      bitIdx_q <= '0;
      presc_q  <= '0;
      data_q   <= '0;
      parEn_q  <= 1'b0;
      parTyp_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitIdx_q <= bitIdx_d;
      presc_q  <= presc_d;
      data_q   <= data_d;
      parEn_q  <= parEn_d;
      parTyp_q <= parTyp_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: one instance at PRESCALE=1, one at PRESCALE=4,
// driven and sampled on the falling clock edge.
module tb_uart_tx_frame;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] pData1, pData4;
  logic       dv1, dv4, parEn1, parEn4, parTyp1, parTyp4;
  logic       tx1, tx4, busy1, busy4;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE(1)) dut1 (
    .CLK(CLK), .RST(RST), .P_DATA(pData1), .Data_Valid(dv1),
    .PAR_EN(parEn1), .PAR_TYP(parTyp1), .TX_OUT(tx1), .Busy(busy1)
  );

  uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE(4)) dut4 (
    .CLK(CLK), .RST(RST), .P_DATA(pData4), .Data_Valid(dv4),
    .PAR_EN(parEn4), .PAR_TYP(parTyp4), .TX_OUT(tx4), .Busy(busy4)
  );

  // Pulses Data_Valid for one cycle; returns on the falling edge where the start bit is visible
  task automatic startFrame1(input logic [7:0] d, input logic pe, input logic pt);
    @(negedge CLK);
    pData1 = d; parEn1 = pe; parTyp1 = pt; dv1 = 1'b1;
    @(negedge CLK);
    dv1 = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    pData1 = '0; dv1 = 0; parEn1 = 0; parTyp1 = 0;
    pData4 = '0; dv4 = 0; parEn4 = 0; parTyp4 = 0;
    #1;
    checks++;
    if ({tx1, busy1, tx4, busy4} !== 4'b1010) begin
      failures++;
      $display("[TB] FAIL reset_async got tx1=%b busy1=%b tx4=%b busy4=%b want 1 0 1 0", tx1, busy1, tx4, busy4);
    end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({tx1, busy1, tx4, busy4} !== 4'b1010) begin
      failures++;
      $display("[TB] FAIL reset_idle got tx1=%b busy1=%b tx4=%b busy4=%b want 1 0 1 0", tx1, busy1, tx4, busy4);
    end
  endtask

  task automatic test_no_parity;
    logic [9:0] frame;
    frame = {1'b1, 8'hA5, 1'b0};
    startFrame1(8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge CLK);
      checks++;
      if ({tx1, busy1} !== {frame[i], 1'b1}) begin
        failures++;
        $display("[TB] FAIL a5_bit%0d got tx=%b busy=%b want tx=%b busy=1", i, tx1, busy1, frame[i]);
      end
    end
    @(negedge CLK);
    checks++;
    if ({tx1, busy1} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL a5_end got tx=%b busy=%b want tx=1 busy=0", tx1, busy1);
    end
  endtask

  task automatic test_parity;
    logic [10:0] frame;
    for (int t = 0; t < 2; t++) begin
      // 8'h03 has two ones: even parity bit 0, odd parity bit 1
      frame = {1'b1, (t == 1), 8'h03, 1'b0};
      startFrame1(8'h03, 1'b1, t[0]);
      for (int i = 0; i < 11; i++) begin
        if (i > 0) @(negedge CLK);
        checks++;
        if ({tx1, busy1} !== {frame[i], 1'b1}) begin
          failures++;
          $display("[TB] FAIL par%0d_bit%0d got tx=%b busy=%b want tx=%b busy=1", t, i, tx1, busy1, frame[i]);
        end
      end
      @(negedge CLK);
      checks++;
      if ({tx1, busy1} !== 2'b10) begin
        failures++;
        $display("[TB] FAIL par%0d_end got tx=%b busy=%b want tx=1 busy=0", t, tx1, busy1);
      end
    end
  endtask

  task automatic test_prescale;
    logic [10:0] frame;
    // 8'h80 has one set bit, so the odd parity bit is 0
    frame = {1'b1, 1'b0, 8'h80, 1'b0};
    @(negedge CLK);
    pData4 = 8'h80; parEn4 = 1'b1; parTyp4 = 1'b1; dv4 = 1'b1;
    @(negedge CLK);
    dv4 = 1'b0;
    for (int i = 0; i < 44; i++) begin
      if (i > 0) @(negedge CLK);
      checks++;
      if ({tx4, busy4} !== {frame[i/4], 1'b1}) begin
        failures++;
        $display("[TB] FAIL ps4_cycle%0d got tx=%b busy=%b want tx=%b busy=1", i, tx4, busy4, frame[i/4]);
      end
    end
    @(negedge CLK);
    checks++;
    if ({tx4, busy4} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL ps4_end got tx=%b busy=%b want tx=1 busy=0", tx4, busy4);
    end
  endtask

  task automatic test_busy_ignore;
    logic [9:0] frame;
    frame = {1'b1, 8'h00, 1'b0};
    startFrame1(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge CLK);
      if (i == 3) begin
        dv1 = 1'b1; pData1 = 8'hFF; parEn1 = 1'b1;
      end
      if (i == 4) dv1 = 1'b0;
      checks++;
      if ({tx1, busy1} !== {frame[i], 1'b1}) begin
        failures++;
        $display("[TB] FAIL busy_ign_bit%0d got tx=%b busy=%b want tx=%b busy=1", i, tx1, busy1, frame[i]);
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checks++;
      if ({tx1, busy1} !== 2'b10) begin
        failures++;
        $display("[TB] FAIL busy_ign_idle%0d got tx=%b busy=%b want tx=1 busy=0", i, tx1, busy1);
      end
    end
    parEn1 = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [9:0] frame;
    frame = {1'b1, 8'h55, 1'b0};
    @(negedge CLK);
    pData1 = 8'h55; parEn1 = 1'b0; parTyp1 = 1'b0; dv1 = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge CLK);
        checks++;
        if ({tx1, busy1} !== {frame[i], 1'b1}) begin
          failures++;
          $display("[TB] FAIL b2b_f%0d_bit%0d got tx=%b busy=%b want tx=%b busy=1", f, i, tx1, busy1, frame[i]);
        end
      end
      @(negedge CLK);
      if (f == 1) dv1 = 1'b0;
      checks++;
      if ({tx1, busy1} !== 2'b10) begin
        failures++;
        $display("[TB] FAIL b2b_gap%0d got tx=%b busy=%b want tx=1 busy=0", f, tx1, busy1);
      end
    end
    @(negedge CLK);
    checks++;
    if ({tx1, busy1} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL b2b_stop got tx=%b busy=%b want tx=1 busy=0", tx1, busy1);
    end
  endtask

  task automatic test_reset_midframe;
    logic [9:0] frame;
    startFrame1(8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    checks++;
    if ({tx1, busy1} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL mid_pre_reset got tx=%b busy=%b want tx=0 busy=1", tx1, busy1);
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({tx1, busy1} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL mid_async_reset got tx=%b busy=%b want tx=1 busy=0", tx1, busy1);
    end
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checks++;
      if ({tx1, busy1} !== 2'b10) begin
        failures++;
        $display("[TB] FAIL mid_post_idle%0d got tx=%b busy=%b want tx=1 busy=0", i, tx1, busy1);
      end
    end
    frame = {1'b1, 8'h3C, 1'b0};
    startFrame1(8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge CLK);
      checks++;
      if ({tx1, busy1} !== {frame[i], 1'b1}) begin
        failures++;
        $display("[TB] FAIL mid_3c_bit%0d got tx=%b busy=%b want tx=%b busy=1", i, tx1, busy1, frame[i]);
      end
    end
    @(negedge CLK);
    checks++;
    if ({tx1, busy1} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL mid_3c_end got tx=%b busy=%b want tx=1 busy=0", tx1, busy1);
    end
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity();
    test_prescale();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
